// File: rtl/card_shoe_dealer.sv
// card_shoe_dealer
// Draws random cards from an external shoe memory of N = 52*NUM_DECKS words
// laid out as {suit[6:5], used[4], rank[3:0]}. A draw picks a pseudo-random
// address from an LFSR. If the LFSR keeps landing on out-of-range or used
// slots, the draw falls back to a linear scan. The block can also clear every
// used flag.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   request_card        level request to draw one card (sampled in IDLE)
//   clear_shoe          request to clear all used flags (sampled in IDLE)
//   deck_read_data      combinational read word at deck_addr
//   deck_addr           memory address
//   deck_read_en        read strobe
//   deck_write_en       write strobe (memory writes on the clk edge)
//   deck_write_data     write word
//   card_ready          one-cycle pulse, card_data_out valid
//   card_data_out       last drawn card word (used bit set)
//   cards_left          count of unused cards
//   shoe_empty          cards_left == 0
//   draw_error          one-cycle pulse, request refused
//   busy                high whenever the block is not idle
module card_shoe_dealer #(
  parameter int         NUM_DECKS = 1,
  parameter int         MAX_RETRY = 15,
  parameter logic [7:0] LFSR_SEED = 8'h29,
  localparam int        N         = 52 * NUM_DECKS,
  localparam int        ADDR_W    = $clog2(N),
  localparam int        LFSR_W    = (NUM_DECKS == 1) ? 6 : (NUM_DECKS == 2) ? 7 : 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request_card,
  input  logic              clear_shoe,
  input  logic [6:0]        deck_read_data,
  output logic [ADDR_W-1:0] deck_addr,
  output logic              deck_read_en,
  output logic              deck_write_en,
  output logic [6:0]        deck_write_data,
  output logic              card_ready,
  output logic [6:0]        card_data_out,
  output logic [ADDR_W:0]   cards_left,
  output logic              shoe_empty,
  output logic              draw_error,
  output logic              busy
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_GEN       = 4'd1;
  localparam logic [3:0] S_READ_WAIT = 4'd2;
  localparam logic [3:0] S_CHECK     = 4'd3;
  localparam logic [3:0] S_MARK      = 4'd4;
  localparam logic [3:0] S_DONE      = 4'd5;
  localparam logic [3:0] S_SCAN      = 4'd6;
  localparam logic [3:0] S_CLR_RD    = 4'd7;
  localparam logic [3:0] S_CLR_WR    = 4'd8;

  localparam int RC_W = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [ADDR_W:0]   N_L     = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W:0]   LAST_L  = (ADDR_W + 1)'(N - 1);
  localparam logic [RC_W-1:0]   RETRY_L = RC_W'(MAX_RETRY);
  localparam logic [8:0]        N_CMP   = 9'(N);

  // Tap masks: W6 x^6+x^5+1, W7 x^7+x^6+1, W8 x^8+x^6+x^5+x^4+1
  localparam logic [7:0] TAPS_ALL = (NUM_DECKS == 1) ? 8'h30 :
                                    (NUM_DECKS == 2) ? 8'h60 : 8'hB8;
  localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] SEED_RAW = LFSR_SEED[LFSR_W-1:0];
  // An all-zero LFSR would lock up, so a zero seed becomes 1
  localparam logic [LFSR_W-1:0] SEED_L   = (SEED_RAW == '0) ? LFSR_W'(1) : SEED_RAW;

  localparam logic [6:0] USED_BIT = 7'b001_0000;

  // Fibonacci step: shift left, feedback XOR of taps into bit 0
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    logic fb;
    fb = ^(v & TAPS);
    return {v[LFSR_W-2:0], fb};
  endfunction

  logic [3:0]        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [6:0]        cap_q, cap_d;
  logic [6:0]        card_q, card_d;
  logic [ADDR_W:0]   left_q, left_d;
  logic [RC_W-1:0]   rej_q, rej_d;
  logic              scan_q, scan_d;
  logic              err_q, err_d;

  logic [LFSR_W-1:0] lfsr_nxt_s;
  logic [8:0]        cand_s;
  logic              rd_s, wr_s;

  // Candidate index derived from the LFSR value this GEN cycle produces
  always_comb begin
    lfsr_nxt_s = lfsr_step(lfsr_q);
    cand_s     = 9'(lfsr_nxt_s) - 9'd1;
  end

  // Next-state logic for the draw / clear sequencer
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cap_d   = cap_q;
    card_d  = card_q;
    left_d  = left_q;
    rej_d   = rej_q;
    scan_d  = scan_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_shoe) begin
          ptr_d   = '0;
          state_d = S_CLR_RD;
        end else if (request_card) begin
          if (left_q != '0) begin
            state_d = S_GEN;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GEN: begin
        lfsr_d = lfsr_nxt_s;
        if (cand_s >= N_CMP) begin
          // Out-of-range candidate is a reject; too many switches to scan
          if (rej_q >= RETRY_L) begin
            scan_d  = 1'b1;
            ptr_d   = '0;
            state_d = S_SCAN;
          end else begin
            rej_d = rej_q + RC_W'(1);
          end
        end else begin
          idx_d   = cand_s[ADDR_W-1:0];
          state_d = S_READ_WAIT;
        end
      end
      S_READ_WAIT: begin
        cap_d   = deck_read_data;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!cap_q[4]) begin
          state_d = S_MARK;
        end else if (scan_q) begin
          // Scan walked past the last address: nothing unused to give out
          if (ptr_q == LAST_L) begin
            err_d   = 1'b1;
            rej_d   = '0;
            scan_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            ptr_d   = ptr_q + (ADDR_W + 1)'(1);
            state_d = S_SCAN;
          end
        end else if (rej_q >= RETRY_L) begin
          scan_d  = 1'b1;
          ptr_d   = '0;
          state_d = S_SCAN;
        end else begin
          rej_d   = rej_q + RC_W'(1);
          state_d = S_GEN;
        end
      end
      S_SCAN: begin
        idx_d   = ptr_q[ADDR_W-1:0];
        state_d = S_READ_WAIT;
      end
      S_MARK: begin
        card_d  = cap_q | USED_BIT;
        left_d  = left_q - (ADDR_W + 1)'(1);
        state_d = S_DONE;
      end
      S_DONE: begin
        rej_d   = '0;
        scan_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_CLR_RD: begin
        cap_d   = deck_read_data;
        state_d = S_CLR_WR;
      end
      S_CLR_WR: begin
        ptr_d = ptr_q + (ADDR_W + 1)'(1);
        if (ptr_q == LAST_L) begin
          left_d  = N_L;
          state_d = S_IDLE;
        end else begin
          state_d = S_CLR_RD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory strobe / address decode from the current state
  always_comb begin
    deck_addr       = '0;
    rd_s            = 1'b0;
    wr_s            = 1'b0;
    deck_write_data = 7'd0;
    case (state_q)
      S_READ_WAIT: begin
        deck_addr = idx_q;
        rd_s      = 1'b1;
      end
      S_MARK: begin
        deck_addr       = idx_q;
        wr_s            = 1'b1;
        deck_write_data = cap_q | USED_BIT;
      end
      S_CLR_RD: begin
        deck_addr = ptr_q[ADDR_W-1:0];
        rd_s      = 1'b1;
      end
      S_CLR_WR: begin
        deck_addr       = ptr_q[ADDR_W-1:0];
        wr_s            = 1'b1;
        deck_write_data = cap_q & ~USED_BIT;
      end
      default: begin
        deck_addr = '0;
      end
    endcase
  end

  // Strobes are masked by rst so an aborted MARK/CLR_WR never writes memory
  always_comb begin
    deck_read_en  = rd_s & ~rst;
    deck_write_en = wr_s & ~rst;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_L;
      idx_q   <= '0;
      ptr_q   <= '0;
      cap_q   <= 7'd0;
      card_q  <= 7'd0;
      left_q  <= N_L;
      rej_q   <= '0;
      scan_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cap_q   <= cap_d;
      card_q  <= card_d;
      left_q  <= left_d;
      rej_q   <= rej_d;
      scan_q  <= scan_d;
      err_q   <= err_d;
    end
  end

  // Status outputs decoded from registers
  always_comb begin
    card_ready    = (state_q == S_DONE);
    card_data_out = card_q;
    cards_left    = left_q;
    shoe_empty    = (left_q == '0);
    draw_error    = err_q;
    busy          = (state_q != S_IDLE);
  end

endmodule
